// File: rtl/i2c_bus_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the I2C bus arbiter.
package i2c_bus_arbiter_pkg;

    localparam int unsigned I2C_ADDR_W = 7;
    localparam int unsigned I2C_DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER,
        LOAD,
        STOP,
        DONE
    } arb_state_t;

    // A requested length of zero still moves one byte.
    function automatic int unsigned eff_len(input int unsigned len);
        return (len == 0) ? 1 : len;
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and i2c_master-side signals of the arbiter.
// The master modport is the arbiter's view; slave is the surrounding logic.
interface i2c_bus_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4
) ();
    import i2c_bus_arbiter_pkg::*;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_rw;
    logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr;
    logic [NUM_REQ*LEN_W-1:0]      req_len;
    logic [NUM_REQ*I2C_DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]            gnt;
    logic [NUM_REQ-1:0]            wdata_pop;
    logic [NUM_REQ-1:0]            xfer_done;
    logic [NUM_REQ-1:0]            xfer_nack;

    logic                          m_start;
    logic                          m_stop;
    logic                          m_rw;
    logic [I2C_ADDR_W-1:0]         m_addr;
    logic [I2C_DATA_W-1:0]         m_wdata;
    logic                          m_idle;
    logic                          m_byte_done;
    logic                          m_nack;

    modport master (
        input  req_valid, req_rw, req_addr, req_len, req_wdata,
        input  m_idle, m_byte_done, m_nack,
        output gnt, wdata_pop, xfer_done, xfer_nack,
        output m_start, m_stop, m_rw, m_addr, m_wdata
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_len, req_wdata,
        output m_idle, m_byte_done, m_nack,
        input  gnt, wdata_pop, xfer_done, xfer_nack,
        input  m_start, m_stop, m_rw, m_addr, m_wdata
    );

endinterface

// File: rtl/i2c_bus_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester after ptr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    // Scan N positions starting just past the last winner.
    always_comb begin
        logic found;
        int unsigned j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Round-robin sharing of one i2c_master between NUM_REQ requesters, with
// per-transaction sequencing, byte counting and NACK/timeout reporting.
module i2c_bus_arbiter
    import i2c_bus_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic             clk,
    input logic             reset,
    i2c_bus_arbiter_if.master bus
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);

    arb_state_t            state;
    logic [IDX_W-1:0]      idx;
    logic [IDX_W-1:0]      ptr;
    logic [LEN_W-1:0]      remaining;
    logic [TMO_W-1:0]      tmo;
    logic                  nack_flag;

    logic [NUM_REQ-1:0]    gnt_q;
    logic [NUM_REQ-1:0]    pop_q;
    logic [NUM_REQ-1:0]    done_q;
    logic [NUM_REQ-1:0]    nack_q;
    logic                  start_q;
    logic                  stop_q;
    logic                  rw_q;
    logic [I2C_ADDR_W-1:0] addr_q;
    logic [I2C_DATA_W-1:0] wdata_q;

    logic [NUM_REQ-1:0]    win_gnt;
    logic [IDX_W-1:0]      win_idx;
    logic [LEN_W-1:0]      win_len;
    logic [I2C_ADDR_W-1:0] win_addr;
    logic [I2C_DATA_W-1:0] win_wdata;
    logic [I2C_DATA_W-1:0] cur_wdata;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (win_gnt),
        .idx (win_idx)
    );

    assign win_len   = bus.req_len[32'(win_idx)*LEN_W +: LEN_W];
    assign win_addr  = bus.req_addr[32'(win_idx)*I2C_ADDR_W +: I2C_ADDR_W];
    assign win_wdata = bus.req_wdata[32'(win_idx)*I2C_DATA_W +: I2C_DATA_W];
    assign cur_wdata = bus.req_wdata[32'(idx)*I2C_DATA_W +: I2C_DATA_W];

    // Transaction sequencer; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            ptr       <= IDX_W'(NUM_REQ - 1);
            remaining <= '0;
            tmo       <= '0;
            nack_flag <= 1'b0;
            gnt_q     <= '0;
            pop_q     <= '0;
            done_q    <= '0;
            nack_q    <= '0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            start_q <= 1'b0;
            pop_q   <= '0;
            done_q  <= '0;
            nack_q  <= '0;
            unique case (state)
                IDLE: begin
                    if (bus.m_idle && |bus.req_valid) begin
                        idx       <= win_idx;
                        gnt_q     <= win_gnt;
                        rw_q      <= bus.req_rw[win_idx];
                        addr_q    <= win_addr;
                        remaining <= LEN_W'(eff_len(32'(win_len)));
                        wdata_q   <= win_wdata;
                        state     <= START;
                    end
                end
                START: begin
                    start_q <= 1'b1;
                    stop_q  <= (remaining == LEN_W'(1));
                    tmo     <= '0;
                    state   <= XFER;
                end
                XFER: begin
                    // A byte completion in the same cycle as expiry wins over the timeout.
                    if (bus.m_byte_done) begin
                        if (bus.m_nack) begin
                            nack_flag <= 1'b1;
                            stop_q    <= 1'b1;
                            state     <= STOP;
                        end else if (remaining == LEN_W'(1)) begin
                            stop_q <= 1'b1;
                            state  <= STOP;
                        end else begin
                            remaining <= remaining - 1'b1;
                            stop_q    <= (remaining == LEN_W'(2));
                            pop_q     <= rw_q ? '0 : gnt_q;
                            tmo       <= '0;
                            state     <= LOAD;
                        end
                    end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                        nack_flag <= 1'b1;
                        stop_q    <= 1'b1;
                        state     <= STOP;
                    end else begin
                        tmo <= tmo + 1'b1;
                    end
                end
                LOAD: begin
                    // Requester presented the next byte while wdata_pop was high.
                    wdata_q <= cur_wdata;
                    state   <= XFER;
                end
                STOP: begin
                    // Done/nack pulse during DONE gives the requester a cycle to drop
                    // req_valid before the next arbitration.
                    if (bus.m_idle) begin
                        stop_q    <= 1'b0;
                        done_q    <= gnt_q;
                        nack_q    <= nack_flag ? gnt_q : '0;
                        gnt_q     <= '0;
                        ptr       <= idx;
                        nack_flag <= 1'b0;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.wdata_pop = pop_q;
    assign bus.xfer_done = done_q;
    assign bus.xfer_nack = nack_q;
    assign bus.m_start   = start_q;
    assign bus.m_stop    = stop_q;
    assign bus.m_rw      = rw_q;
    assign bus.m_addr    = addr_q;
    assign bus.m_wdata   = wdata_q;

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Self-checking bench for i2c_bus_arbiter: the bench plays both the requesters
// and the i2c_master, and predicts grants with a simple round-robin model.
module tb_i2c_bus_arbiter;

    localparam int NR  = 4;
    localparam int LW  = 4;
    localparam int TMO = 16;

    logic clk;
    logic reset;

    i2c_bus_arbiter_if #(.NUM_REQ(NR), .LEN_W(LW)) bus ();

    i2c_bus_arbiter #(
        .NUM_REQ (NR),
        .LEN_W   (LW),
        .TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int last;                 // model: index of last served requester
    logic [NR-1:0] vld;
    bit   rw_a   [NR];
    logic [6:0] addr_a [NR];
    logic [3:0] len_a  [NR];
    logic [7:0] wbytes [NR][16];
    int   bptr   [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_reqs();
        bus.req_valid = vld;
        for (int r = 0; r < NR; r++) begin
            bus.req_rw[r]          = rw_a[r];
            bus.req_addr[r*7 +: 7] = addr_a[r];
            bus.req_len[r*4 +: 4]  = len_a[r];
            bus.req_wdata[r*8 +: 8] = wbytes[r][bptr[r]];
        end
    endtask

    function automatic int pick(input logic [NR-1:0] v, input int lst);
        for (int i = 1; i <= NR; i++) begin
            if (v[(lst + i) % NR]) return (lst + i) % NR;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 0);
        check({tag, "_pop"},   32'(bus.wdata_pop), 0);
        check({tag, "_done"},  32'(bus.xfer_done), 0);
        check({tag, "_nack"},  32'(bus.xfer_nack), 0);
        check({tag, "_start"}, 32'(bus.m_start), 0);
        check({tag, "_stop"},  32'(bus.m_stop), 0);
        check({tag, "_mbus"},  {16'h0, 1'b0, bus.m_addr, bus.m_wdata}, 0);
    endtask

    // Serve one transaction of requester r; called while the DUT is idle and the
    // request inputs for this cycle are already driven.
    task automatic serve(input int r, input int nack_at, input bit tmo_mode, input bit drop_after);
        int n;
        int len;
        bit exp_nack;
        logic [NR-1:0] oh;
        oh  = NR'(1) << r;
        len = (len_a[r] == 0) ? 1 : int'(len_a[r]);
        exp_nack = tmo_mode || (nack_at >= 1 && nack_at <= len);
        step();
        check("gnt", 32'(bus.gnt), 32'(oh));
        check("start_early", 32'(bus.m_start), 0);
        step();
        check("start", 32'(bus.m_start), 1);
        check("rw", 32'(bus.m_rw), 32'(rw_a[r]));
        check("addr", 32'(bus.m_addr), 32'(addr_a[r]));
        check("wdata0", 32'(bus.m_wdata), 32'(wbytes[r][bptr[r]]));
        check("stop0", 32'(bus.m_stop), 32'(len == 1));
        bus.m_idle = 1'b0;
        step();
        check("start_pulse", 32'(bus.m_start), 0);
        if (tmo_mode) begin
            n = 1;
            while (!bus.m_stop && n < TMO + 8) begin
                step();
                n++;
            end
            check("tmo_cycles", 32'(n), 32'(TMO));
        end else begin
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) begin
                    check("stop_lvl", 32'(bus.m_stop), 32'(k == len - 1));
                    check("gnt_hold", 32'(bus.gnt), 32'(oh));
                    step();
                end
                if (!rw_a[r]) check("wdata", 32'(bus.m_wdata), 32'(wbytes[r][bptr[r]]));
                bus.m_byte_done = 1'b1;
                bus.m_nack      = (k + 1 == nack_at);
                step();
                bus.m_byte_done = 1'b0;
                bus.m_nack      = 1'b0;
                if (k + 1 == nack_at || k == len - 1) begin
                    check("stop_end", 32'(bus.m_stop), 1);
                    check("pop_end", 32'(bus.wdata_pop), 0);
                    break;
                end
                check("pop", 32'(bus.wdata_pop), rw_a[r] ? 0 : 32'(oh));
                if (!rw_a[r]) begin
                    bptr[r]++;
                    drive_reqs();
                end
                step();
            end
        end
        // Master still busy; a stray byte_done here must be ignored.
        check("stop_hold", 32'(bus.m_stop), 1);
        bus.m_byte_done = 1'b1;
        step();
        bus.m_byte_done = 1'b0;
        check("stop_hold2", 32'(bus.m_stop), 1);
        check("pop_stop", 32'(bus.wdata_pop), 0);
        check("done_early", 32'(bus.xfer_done), 0);
        bus.m_idle = 1'b1;
        step();
        check("done", 32'(bus.xfer_done), 32'(oh));
        check("nack", 32'(bus.xfer_nack), exp_nack ? 32'(oh) : 0);
        check("gnt_clr", 32'(bus.gnt), 0);
        check("stop_clr", 32'(bus.m_stop), 0);
        last = r;
        if (drop_after) begin
            vld[r] = 1'b0;
            drive_reqs();
        end
        step();
        check("done_pulse", 32'(bus.xfer_done), 0);
    endtask

    initial begin
        int w;
        checks = 0;
        errors = 0;
        last   = NR - 1;
        vld    = '0;
        reset  = 1'b1;
        bus.m_idle      = 1'b1;
        bus.m_byte_done = 1'b0;
        bus.m_nack      = 1'b0;
        for (int r = 0; r < NR; r++) begin
            rw_a[r] = 1'b0; addr_a[r] = '0; len_a[r] = '0; bptr[r] = 0;
            for (int k = 0; k < 16; k++) wbytes[r][k] = 8'($urandom);
        end
        drive_reqs();
        repeat (2) step();
        check_all_zero("rst");
        reset = 1'b0;
        step();
        check_all_zero("post_rst");

        // Write of two bytes from requester 0.
        addr_a[0] = 7'h50; len_a[0] = 4'd2; rw_a[0] = 1'b0;
        wbytes[0][0] = 8'hA5; wbytes[0][1] = 8'h3C; bptr[0] = 0;
        vld = 4'b0001;
        drive_reqs();
        serve(0, 0, 0, 1);

        // All requesting and held: round-robin rotation.
        for (int r = 0; r < NR; r++) begin
            rw_a[r] = r[0]; addr_a[r] = 7'($urandom); len_a[r] = 4'($urandom_range(1, 3));
            bptr[r] = 0;
        end
        vld = 4'b1111;
        drive_reqs();
        for (int t = 0; t < 5; t++) begin
            w = pick(vld, last);
            serve(w, 0, 0, 0);
        end
        vld = '0;
        drive_reqs();
        step();

        // NACK on the first byte of a three-byte write.
        rw_a[2] = 1'b0; len_a[2] = 4'd3; bptr[2] = 0;
        vld = 4'b0100;
        drive_reqs();
        serve(2, 1, 0, 1);

        // No byte completion at all: timeout abort.
        rw_a[3] = 1'b0; len_a[3] = 4'd2; bptr[3] = 0;
        vld = 4'b1000;
        drive_reqs();
        serve(3, 0, 1, 1);

        // Zero-length read counts as one byte.
        rw_a[1] = 1'b1; len_a[1] = 4'd0; bptr[1] = 0;
        vld = 4'b0010;
        drive_reqs();
        serve(1, 0, 0, 1);

        // Reset in the middle of a transfer.
        rw_a[2] = 1'b0; len_a[2] = 4'd4; bptr[2] = 0;
        vld = 4'b0100;
        drive_reqs();
        repeat (3) step();
        check("mid_gnt", 32'(bus.gnt), 32'(4'b0100));
        reset = 1'b1;
        #1;
        check_all_zero("async_rst");
        step();
        reset = 1'b0;
        bus.m_idle = 1'b1;
        last = NR - 1;
        for (int r = 0; r < NR; r++) bptr[r] = 0;
        vld = 4'b1111;
        drive_reqs();
        serve(0, 0, 0, 1);
        vld = '0;
        drive_reqs();
        step();

        // Randomized transactions against the round-robin model.
        for (int t = 0; t < 20; t++) begin
            vld = 4'($urandom_range(1, 15));
            for (int r = 0; r < NR; r++) begin
                rw_a[r]   = 1'($urandom);
                addr_a[r] = 7'($urandom);
                len_a[r]  = 4'($urandom_range(0, 6));
                bptr[r]   = 0;
                for (int k = 0; k < 16; k++) wbytes[r][k] = 8'($urandom);
            end
            drive_reqs();
            w = pick(vld, last);
            serve(w, int'($urandom_range(0, 8)), 0, 1);
            vld = '0;
            drive_reqs();
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
